mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the register file write port. Also owns the HI/LO special registers.
- Captures MEM results and performs big-endian load-data extraction (byte/half/word, signed and unsigned).
- Drives the register file's write enable, write address and write data.
- Supports stall, bubble insertion and flush. Provides same-cycle-forwarded HI/LO read values to the EX stage.

Parameters:
- DATA_W, 32, datapath width (only 32 is supported).
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_mem  in  1  MEM stage stalled this cycle.
- stall_wb  in  1  WB stage stalled this cycle.
- flush  in  1  exception/flush: turn the stage into a bubble.
- mem_wreg  in  1  MEM instruction writes a GPR.
- mem_wd  in  ADDR_W  destination GPR.
- mem_wdata  in  DATA_W  ALU result for non-load instructions.
- mem_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6/7 reserved.
- mem_addr_lo  in  2  byte offset of the load address.
- mem_rdata  in  DATA_W  raw data-memory read word.
- mem_whilo  in  1  MEM instruction writes HI/LO.
- mem_hi, mem_lo  in  DATA_W  HI/LO values to write.
- wb_wreg  out  1  register file write enable.
- wb_wd  out  ADDR_W  register file write address.
- wb_wdata  out  DATA_W  register file write data.
- wb_align_err  out  1  one-cycle flag: misaligned or reserved load was captured.
- hi_o, lo_o  out  DATA_W  current HI/LO, with forwarding of a pending write.

Behaviour:
- Reset (async, rst=1): all registered outputs 0, hi_reg = lo_reg = 0, hi_o = lo_o = 0. Reset takes effect immediately, mid-stall or mid-write. Any pending WB/HI-LO write is discarded.
- Update priority at each posedge, highest first:
  1. flush → bubble.
  2. stall_mem=1 and stall_wb=0 → bubble.
  3. stall_mem=0 → capture MEM inputs.
  4. Otherwise (both stalled) → hold all registers.
- Bubble: wb_wreg=0, wb_wd=0, wb_wdata=0, internal wb_whilo=0, wb_align_err=0.
- Capture latency: one cycle. Values presented in cycle N appear on wb_* in cycle N+1.
- Load extraction happens before the register; byte lane k sits at bits [31-8k : 24-8k] (big-endian).
  - LB/LBU: select lane mem_addr_lo, then sign- or zero-extend to 32 bits.
  - LH/LHU: addr_lo=0 → bits 31:16; addr_lo=2 → bits 15:0; sign- or zero-extend.
  - LW: whole word, addr_lo must be 0.
  - op 0: wb_wdata = mem_wdata.
- Misaligned load (LH/LHU with addr_lo[0]=1, LW with addr_lo≠0) or reserved op 6/7: wb_wreg forced 0, wb_wdata=0, wb_align_err=1 for exactly that captured instruction. If the stage holds, wb_align_err holds with it.
- mem_wd=0 with mem_wreg=1: wb_wreg forced 0.
- HI/LO write: at the posedge after capture, if registered wb_whilo=1 and the stage is not stalled-holding, hi_reg ← wb_hi and lo_reg ← wb_lo. A held instruction writes exactly once.
- hi_o/lo_o (combinational): equal wb_hi/wb_lo when wb_whilo=1, else hi_reg/lo_reg. EX therefore sees a pending HI/LO write in the same cycle.
- Flush and stall together: flush wins.
- A flush while wb holds an instruction whose HI/LO write has not yet committed cancels that write.

Decomposition:
- Shared defines package holds: load_op encodings (LOAD_NONE, LB, LBU, LH, LHU, LW), RstEnable, WriteEnable/Disable, ZeroWord, RegAddrBus/RegBus widths.
- One natural sub-module: load_align, a purely combinational extractor. Inputs: load_op, addr_lo, rdata. Outputs: data, err.

Test Plan:
- Reset: assert rst mid-cycle while wb_wreg=1 → all outputs 0 immediately; hi_o = lo_o = 0.
- Loads: mem_rdata=0x80FF7F01, LB addr 1 → wb_wdata=0xFFFFFFFF.
  - LBU addr 0 → 0x00000080.
  - LH addr 2 → 0x00007F01.
  - LHU addr 0 → 0x000080FF.
  - LW addr 0 → 0x80FF7F01.
  - Each appears one cycle after capture, with wb_wreg=1.
- Misaligned load: LW addr 2 with mem_wreg=1, wd=5 → wb_wreg=0, wb_align_err=1 for one cycle.
- Stall: stall_mem=1, stall_wb=0 → next cycle is a bubble (wb_wreg=0).
- Hold: stall_mem=stall_wb=1 for 3 cycles → wb_* unchanged; a held HI/LO write (hi=0x12345678) commits only once.
- HI/LO forwarding and flush: capture whilo with hi=0xA, lo=0xB → hi_o=0xA, lo_o=0xB in the capture+1 cycle and afterwards. A flush arriving together with a new capture → bubble, and hi_reg keeps its old value.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline register: load encodings,
// write-enable levels and register-file bus widths.
package mem_wb_stage_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic              RstEnable    = 1'b1;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord     = '0;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LB        = 3'd1,
    LBU       = 3'd2,
    LH        = 3'd3,
    LHU       = 3'd4,
    LW        = 3'd5
  } load_op_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational big-endian load extractor: picks the byte/half/word lane
// from the raw read word and flags misaligned or reserved load ops.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]        load_op,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] rdata,
  output logic [RegBus-1:0] data,
  output logic              err
);

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    // Byte lane 0 is the most significant byte.
    case (addr_lo)
      2'd0:    lane = rdata[31:24];
      2'd1:    lane = rdata[23:16];
      2'd2:    lane = rdata[15:8];
      default: lane = rdata[7:0];
    endcase
    half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    data = ZeroWord;
    err  = 1'b0;
    case (load_op_t'(load_op))
      LOAD_NONE: data = ZeroWord;
      LB:        data = {{24{lane[7]}}, lane};
      LBU:       data = {24'h0, lane};
      LH:        if (addr_lo[0]) err = 1'b1;
                 else data = {{16{half[15]}}, half};
      LHU:       if (addr_lo[0]) err = 1'b1;
                 else data = {16'h0, half};
      LW:        if (addr_lo != 2'd0) err = 1'b1;
                 else data = rdata;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register driving the register-file write port; also owns
// HI/LO and forwards a pending HI/LO write to EX in the same cycle.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_align_err,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] ld_data;
  logic              ld_err;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_wreg;
  logic              bubble;
  logic              hold;
  logic              commit;

  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;

  load_align u_load_align (
    .load_op (mem_load_op),
    .addr_lo (mem_addr_lo),
    .rdata   (mem_rdata),
    .data    (ld_data),
    .err     (ld_err)
  );

  always_comb begin
    bubble    = flush || (stall_mem && !stall_wb);
    hold      = !flush && stall_mem && stall_wb;
    // The instruction in WB retires its HI/LO write unless it is held or flushed.
    commit    = wb_whilo && !flush && !hold;
    cap_wreg  = mem_wreg && (mem_wd != '0) && !ld_err;
    cap_wdata = ld_err ? ZeroWord
              : (load_op_t'(mem_load_op) == LOAD_NONE) ? mem_wdata : ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wb_wreg      <= WriteDisable;
      wb_wd        <= '0;
      wb_wdata     <= '0;
      wb_align_err <= 1'b0;
      wb_whilo     <= 1'b0;
      wb_hi        <= '0;
      wb_lo        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      if (commit) begin
        hi_reg <= wb_hi;
        lo_reg <= wb_lo;
      end
      if (bubble) begin
        wb_wreg      <= WriteDisable;
        wb_wd        <= '0;
        wb_wdata     <= '0;
        wb_align_err <= 1'b0;
        wb_whilo     <= 1'b0;
        wb_hi        <= '0;
        wb_lo        <= '0;
      end else if (!stall_mem) begin
        wb_wreg      <= cap_wreg ? WriteEnable : WriteDisable;
        wb_wd        <= mem_wd;
        wb_wdata     <= cap_wdata;
        wb_align_err <= ld_err;
        wb_whilo     <= mem_whilo;
        wb_hi        <= mem_hi;
        wb_lo        <= mem_lo;
      end
    end
  end

  assign hi_o = wb_whilo ? wb_hi : hi_reg;
  assign lo_o = wb_whilo ? wb_lo : lo_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: reset, load extraction,
// alignment errors, stall/hold/bubble, HI/LO forwarding and flush.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem, stall_wb, flush;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        wb_align_err;
  logic [31:0] hi_o, lo_o;

  int compared = 0;
  int mismatched = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .flush(flush), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
    .mem_wdata(mem_wdata), .mem_load_op(mem_load_op),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .wb_align_err(wb_align_err), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [1:0] alo, input logic [31:0] rdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata; mem_load_op = op;
    mem_addr_lo = alo; mem_rdata = rdata; mem_whilo = whilo; mem_hi = hi; mem_lo = lo;
  endtask

  logic [2:0]  ld_op  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd1};
  logic [1:0]  ld_alo [7] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2};
  logic [31:0] ld_exp [7] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF,
                              32'h80FF7F01, 32'hFFFF80FF, 32'h0000007F};

  initial begin
    rst = 1'b1; stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("rst_wdata", wb_wdata, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Asynchronous reset mid-cycle while a write and a HI/LO write are pending
    drive(1'b1, 5'd3, 32'hDEADBEEF, 3'd0, 2'd0, 32'h0, 1'b1, 32'h55, 32'h66);
    tick();
    chk("pre_rst_wreg", {31'h0, wb_wreg}, 32'h1);
    chk("pre_rst_wd", {27'h0, wb_wd}, 32'd3);
    chk("pre_rst_wdata", wb_wdata, 32'hDEADBEEF);
    chk("pre_rst_hi_fwd", hi_o, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("async_rst_wd", {27'h0, wb_wd}, 32'h0);
    chk("async_rst_wdata", wb_wdata, 32'h0);
    chk("async_rst_hi", hi_o, 32'h0);
    chk("async_rst_lo", lo_o, 32'h0);
    @(negedge clk); rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rst_discard_hi", hi_o, 32'h0);

    // Big-endian load extraction from 0x80FF7F01
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'd7, 32'h0, ld_op[i], ld_alo[i], 32'h80FF7F01, 1'b0, 32'h0, 32'h0);
      tick();
      chk($sformatf("load%0d_wdata", i), wb_wdata, ld_exp[i]);
      chk($sformatf("load%0d_wreg", i), {31'h0, wb_wreg}, 32'h1);
      chk($sformatf("load%0d_err", i), {31'h0, wb_align_err}, 32'h0);
    end

    // Misaligned and reserved loads
    drive(1'b1, 5'd5, 32'h0, 3'd5, 2'd2, 32'h80FF7F01, 1'b0, 32'h0, 32'h0);
    tick();
    chk("lw_mis_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("lw_mis_err", {31'h0, wb_align_err}, 32'h1);
    chk("lw_mis_wdata", wb_wdata, 32'h0);
    drive(1'b1, 5'd5, 32'h11, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("after_mis_err", {31'h0, wb_align_err}, 32'h0);
    chk("after_mis_wreg", {31'h0, wb_wreg}, 32'h1);
    chk("alu_wdata", wb_wdata, 32'h11);
    drive(1'b1, 5'd5, 32'h0, 3'd4, 2'd1, 32'h80FF7F01, 1'b0, 32'h0, 32'h0);
    tick();
    chk("lhu_mis_err", {31'h0, wb_align_err}, 32'h1);
    drive(1'b1, 5'd5, 32'h0, 3'd6, 2'd0, 32'h80FF7F01, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rsvd_err", {31'h0, wb_align_err}, 32'h1);
    chk("rsvd_wreg", {31'h0, wb_wreg}, 32'h0);
    drive(1'b1, 5'd0, 32'h22, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("wd0_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("wd0_err", {31'h0, wb_align_err}, 32'h0);

    // Misaligned flag holds with the stage
    drive(1'b1, 5'd6, 32'h0, 3'd5, 2'd1, 32'h80FF7F01, 1'b0, 32'h0, 32'h0);
    tick();
    stall_mem = 1'b1; stall_wb = 1'b1;
    drive(1'b1, 5'd6, 32'h33, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("err_hold", {31'h0, wb_align_err}, 32'h1);
    stall_mem = 1'b0; stall_wb = 1'b0;
    tick();
    chk("err_release", {31'h0, wb_align_err}, 32'h0);
    chk("err_release_wdata", wb_wdata, 32'h33);

    // MEM stalled, WB free: bubble
    stall_mem = 1'b1;
    drive(1'b1, 5'd9, 32'h99, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("bubble_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("bubble_wdata", wb_wdata, 32'h0);
    chk("bubble_wd", {27'h0, wb_wd}, 32'h0);
    stall_mem = 1'b0;

    // Hold for 3 cycles with a pending HI/LO write
    drive(1'b1, 5'd4, 32'h44, 3'd0, 2'd0, 32'h0, 1'b1, 32'h12345678, 32'h9ABCDEF0);
    tick();
    chk("hilo_cap_hi", hi_o, 32'h12345678);
    stall_mem = 1'b1; stall_wb = 1'b1;
    drive(1'b1, 5'd8, 32'h88, 3'd0, 2'd0, 32'h0, 1'b1, 32'h00000BAD, 32'h00000BAD);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_wd", i), {27'h0, wb_wd}, 32'd4);
      chk($sformatf("hold%0d_wdata", i), wb_wdata, 32'h44);
      chk($sformatf("hold%0d_hi", i), hi_o, 32'h12345678);
    end
    stall_mem = 1'b0; stall_wb = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("hold_commit_hi", hi_o, 32'h12345678);
    chk("hold_commit_lo", lo_o, 32'h9ABCDEF0);

    // HI/LO forwarding then commit
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b1, 32'hA, 32'hB);
    tick();
    chk("fwd_hi", hi_o, 32'hA);
    chk("fwd_lo", lo_o, 32'hB);
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("commit_hi", hi_o, 32'hA);
    chk("commit_lo", lo_o, 32'hB);

    // Flush together with a new capture: bubble, HI unchanged
    flush = 1'b1;
    drive(1'b1, 5'd12, 32'hCC, 3'd0, 2'd0, 32'h0, 1'b1, 32'hC, 32'hC);
    tick();
    flush = 1'b0;
    chk("flush_cap_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("flush_cap_hi", hi_o, 32'hA);

    // Flush cancels an uncommitted HI/LO write
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b1, 32'hD, 32'hE);
    tick();
    chk("pend_hi", hi_o, 32'hD);
    flush = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    flush = 1'b0;
    chk("cancel_hi", hi_o, 32'hA);
    chk("cancel_lo", lo_o, 32'hB);
    tick();
    chk("cancel_hi_later", hi_o, 32'hA);

    // Flush wins over a full stall
    drive(1'b1, 5'd10, 32'h1010, 3'd0, 2'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("pre_flush_wreg", {31'h0, wb_wreg}, 32'h1);
    flush = 1'b1; stall_mem = 1'b1; stall_wb = 1'b1;
    tick();
    flush = 1'b0; stall_mem = 1'b0; stall_wb = 1'b0;
    chk("flush_stall_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("flush_stall_wdata", wb_wdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
